// File: rtl/lot_gate_ctrl.sv
// Two-beam direction detector for one lot entrance: sequences sensors a/b,
// emits enter/exit pulses and keeps a saturating occupancy count. Optional stuck-sequence timeout: PGC_TIMEOUT_EN.
//
// state | meaning
// IDLE  | both beams clear, no vehicle in progress
// E1    | entering: outer beam blocked only
// E2    | entering: both beams blocked
// E3    | entering: inner beam blocked only
// X1    | exiting: inner beam blocked only
// X2    | exiting: both beams blocked
// X3    | exiting: outer beam blocked only
// ERR   | illegal sequence seen, wait for both beams clear
module lot_gate_ctrl #(
   parameter int CAPACITY    = 16,
   parameter int CNT_W       = 5,
   parameter int TIMEOUT_CYC = 2**26
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sens_a,
   input  logic             sens_b,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             enter_pulse,
   output logic             exit_pulse,
   output logic             ovf_pulse,
   output logic             unf_pulse,
   output logic             err_pulse
);

   typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3, ERR} state_t;

   localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

   if (2**CNT_W <= CAPACITY) begin : g_bad_cnt_w
      $error("CNT_W too narrow for CAPACITY");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   state_t     state, nxt;
   logic [1:0] ab;
   logic       ev_enter, ev_exit, to_err, tmo;

   assign ab    = {sens_a, sens_b};
   assign full  = (count == CAP);
   assign empty = (count == '0);

`ifdef PGC_TIMEOUT_EN
   localparam int TMR_W = ($clog2(TIMEOUT_CYC) < 1) ? 1 : $clog2(TIMEOUT_CYC);
   logic [TMR_W-1:0] tmr;

   // Down-counter loaded on entry to a sequence state; terminal count means stuck.
   assign tmo = (state != IDLE) && (state != ERR) && (tmr == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tmr <= '0;
      else if (nxt != state)
         tmr <= (nxt == IDLE || nxt == ERR) ? '0 : TMR_W'(TIMEOUT_CYC - 1);
      else if (state == IDLE || state == ERR)
         tmr <= '0;
      else if (tmr != '0)
         tmr <= tmr - TMR_W'(1);
   end
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      nxt      = state;
      ev_enter = 1'b0;
      ev_exit  = 1'b0;
      case (state)
         IDLE: case (ab)
                  2'b10: nxt = E1;
                  2'b01: nxt = X1;
                  2'b11: nxt = ERR;
                  default: ;
               endcase
         E1:   case (ab)
                  2'b00: nxt = IDLE;
                  2'b11: nxt = E2;
                  2'b01: nxt = ERR;
                  default: ;
               endcase
         E2:   case (ab)
                  2'b10: nxt = E1;
                  2'b01: nxt = E3;
                  2'b00: nxt = ERR;
                  default: ;
               endcase
         E3:   case (ab)
                  2'b11: nxt = E2;
                  2'b00: begin nxt = IDLE; ev_enter = 1'b1; end
                  2'b10: nxt = ERR;
                  default: ;
               endcase
         X1:   case (ab)
                  2'b00: nxt = IDLE;
                  2'b11: nxt = X2;
                  2'b10: nxt = ERR;
                  default: ;
               endcase
         X2:   case (ab)
                  2'b01: nxt = X1;
                  2'b10: nxt = X3;
                  2'b00: nxt = ERR;
                  default: ;
               endcase
         X3:   case (ab)
                  2'b11: nxt = X2;
                  2'b00: begin nxt = IDLE; ev_exit = 1'b1; end
                  2'b01: nxt = ERR;
                  default: ;
               endcase
         ERR:  if (ab == 2'b00) nxt = IDLE;
         default: nxt = IDLE;
      endcase
      if (tmo && nxt == state) nxt = ERR;
      to_err = (nxt == ERR) && (state != ERR);
   end

   // Pulse choice uses the pre-clear count; clr only overrides the count itself.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         enter_pulse <= 1'b0;
         exit_pulse  <= 1'b0;
         ovf_pulse   <= 1'b0;
         unf_pulse   <= 1'b0;
         err_pulse   <= 1'b0;
      end else begin
         state       <= nxt;
         enter_pulse <= ev_enter && (count != CAP);
         ovf_pulse   <= ev_enter && (count == CAP);
         exit_pulse  <= ev_exit && (count != '0);
         unf_pulse   <= ev_exit && (count == '0);
         err_pulse   <= to_err;
         if (clr)
            count <= '0;
         else if (ev_enter && count != CAP)
            count <= count + CNT_W'(1);
         else if (ev_exit && count != '0)
            count <= count - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_lot_gate_ctrl.sv
// Scoreboard bench for lot_gate_ctrl (CAPACITY=4): stimulus pushes expected
// pulse/count pairs, an independent monitor pops them whenever a pulse shows.
module tb_lot_gate_ctrl;
   localparam int CAP = 4;
   localparam int CW  = 3;

   logic          clk = 1'b0;
   logic          reset, sens_a, sens_b, clr;
   logic [CW-1:0] count;
   logic          full, empty, enter_pulse, exit_pulse, ovf_pulse, unf_pulse, err_pulse;

   typedef struct packed {
      logic [4:0]    p;
      logic [CW-1:0] c;
   } exp_t;

   localparam logic [4:0] P_ENTER = 5'b10000;
   localparam logic [4:0] P_EXIT  = 5'b01000;
   localparam logic [4:0] P_OVF   = 5'b00100;
   localparam logic [4:0] P_UNF   = 5'b00010;
   localparam logic [4:0] P_ERR   = 5'b00001;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   mcount   = 0;
   logic [4:0] pulses;

   assign pulses = {enter_pulse, exit_pulse, ovf_pulse, unf_pulse, err_pulse};

   lot_gate_ctrl #(.CAPACITY(CAP), .CNT_W(CW), .TIMEOUT_CYC(100)) dut (
      .clk(clk), .reset(reset), .sens_a(sens_a), .sens_b(sens_b), .clr(clr),
      .count(count), .full(full), .empty(empty),
      .enter_pulse(enter_pulse), .exit_pulse(exit_pulse),
      .ovf_pulse(ovf_pulse), .unf_pulse(unf_pulse), .err_pulse(err_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && pulses != 5'b0) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse got=%b expected=none at %0t", pulses, $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("pulse_vec", int'(pulses), int'(e.p));
            check("event_count", int'(count), int'(e.c));
         end
      end
   end

   task automatic hold(input logic [1:0] ab, input int n);
      {sens_a, sens_b} = ab;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [4:0] p);
      exp_t e;
      e.p = p;
      e.c = CW'(mcount);
      q.push_back(e);
   endtask

   task automatic push_enter();
      if (mcount < CAP) begin mcount++; push(P_ENTER); end
      else push(P_OVF);
   endtask

   task automatic push_exit();
      if (mcount > 0) begin mcount--; push(P_EXIT); end
      else push(P_UNF);
   endtask

   task automatic do_entry();
      hold(2'b00, 5); hold(2'b10, 5); hold(2'b11, 5); hold(2'b01, 5);
      push_enter();
      hold(2'b00, 5);
   endtask

   task automatic do_exit();
      hold(2'b00, 5); hold(2'b01, 5); hold(2'b11, 5); hold(2'b10, 5);
      push_exit();
      hold(2'b00, 5);
   endtask

   initial begin
      reset = 1'b1; sens_a = 1'b0; sens_b = 1'b0; clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_count", int'(count), 0);
      check("rst_empty", int'(empty), 1);
      check("rst_full", int'(full), 0);
      check("rst_pulses", int'(pulses), 0);
      reset = 1'b0;
      hold(2'b00, 3);

      // 1: single entry
      do_entry();
      check("t1_count", int'(count), 1);
      check("t1_empty", int'(empty), 0);

      // 2: single exit
      do_exit();
      check("t2_count", int'(count), 0);
      check("t2_empty", int'(empty), 1);

      // 3: fill to capacity, overflow, clear, underflow
      for (int i = 0; i < 5; i++) begin
         do_entry();
         check("t3_count", int'(count), (i < CAP) ? i + 1 : CAP);
         check("t3_full", int'(full), (i >= CAP - 1) ? 1 : 0);
      end
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      mcount = 0;
      check("clr_count", int'(count), 0);
      do_exit();
      check("t3_unf_count", int'(count), 0);

      // 4: back-out
      hold(2'b10, 5); hold(2'b11, 5); hold(2'b10, 5); hold(2'b00, 5);
      check("t4_count", int'(count), 0);

      // 5: illegal sequence, held error, recovery
      hold(2'b10, 5);
      push(P_ERR);
      hold(2'b01, 8);
      hold(2'b11, 5); hold(2'b10, 5); hold(2'b01, 5);
      hold(2'b00, 5);
      do_entry();
      check("t5_count", int'(count), 1);

      // reset in E2
      hold(2'b10, 5); hold(2'b11, 5);
      reset = 1'b1;
      hold(2'b00, 3);
      mcount = 0;
      check("midrst_count", int'(count), 0);
      check("midrst_pulses", int'(pulses), 0);
      reset = 1'b0;
      hold(2'b00, 3);
      check("midrst_empty", int'(empty), 1);

      // clr coincident with an entry: pulse still issued, count forced to 0
      hold(2'b10, 5); hold(2'b11, 5); hold(2'b01, 5);
      push_enter();
      mcount = 0;
      q[q.size()-1].c = '0;
      {sens_a, sens_b} = 2'b00;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      hold(2'b00, 4);
      check("clr_evt_count", int'(count), 0);

      // 6: hold in E2
      hold(2'b10, 5);
`ifdef PGC_TIMEOUT_EN
      hold(2'b11, 100);
      check("tmo_not_yet", int'(err_pulse), 0);
      push(P_ERR);
      hold(2'b11, 5);
      hold(2'b00, 5);
      check("tmo_count", int'(count), 0);
`else
      hold(2'b11, 1000);
      hold(2'b01, 5);
      push_enter();
      hold(2'b00, 5);
      check("hold_count", int'(count), 1);
`endif

      hold(2'b00, 5);
      check("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
